mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 91 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: dual-port fixed-latency memory model, port 1 read-only, port 2 read/write.
// Define MEM_COLLISION_FWD_EN to forward a same-edge port-2 write to a colliding port-1 read.
module mem_responder #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readM1,
  input  logic [15:0] address1,
  output logic [15:0] data1,
  output logic        ready1,
  input  logic        readM2,
  input  logic        writeM2,
  input  logic [15:0] address2,
  inout  wire  [15:0] data2,
  output logic        ready2
);
  localparam int WORD_SIZE = 16;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
`ifdef MEM_COLLISION_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t r_st1, r_st2, w_nx1, w_nx2;
  logic [3:0] r_cnt1, r_cnt2;
  logic [ADDR_BITS-1:0] r_addr1, r_addr2, w_a1, w_a2;
  logic [WORD_SIZE-1:0] r_mem [2**ADDR_BITS];
  logic [WORD_SIZE-1:0] r_data1, r_data2, r_wd2, w_wd2;
  logic r_wr2, w_wr2, w_req2, w_fin1, w_fin2, w_col, w_unused;
  assign w_unused = ^{address1[15:ADDR_BITS], address2[15:ADDR_BITS]};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st1 <= S_IDLE;
      r_st2 <= S_IDLE;
    end else begin
      r_st1 <= w_nx1;
      r_st2 <= w_nx2;
    end
  end
  // DONE always returns to IDLE, so back-to-back requests are spaced LATENCY+1 cycles
  always_comb begin
    w_req2 = readM2 | writeM2;
    w_nx1 = r_st1 == S_IDLE ? (readM1 ? (LATENCY == 1 ? S_DONE : S_WAIT) : S_IDLE)
          : r_st1 == S_WAIT ? (!readM1 ? S_IDLE : (r_cnt1 == 4'd1 ? S_DONE : S_WAIT))
          : S_IDLE;
    w_nx2 = r_st2 == S_IDLE ? (w_req2 ? (LATENCY == 1 ? S_DONE : S_WAIT) : S_IDLE)
          : r_st2 == S_WAIT ? (!w_req2 ? S_IDLE : (r_cnt2 == 4'd1 ? S_DONE : S_WAIT))
          : S_IDLE;
  end
  // In IDLE the live inputs stand in for the latches so LATENCY=1 completes on the accepting edge
  always_comb begin
    w_a1   = r_st1 == S_IDLE ? address1[ADDR_BITS-1:0] : r_addr1;
    w_a2   = r_st2 == S_IDLE ? address2[ADDR_BITS-1:0] : r_addr2;
    w_wr2  = r_st2 == S_IDLE ? writeM2 : r_wr2;
    w_wd2  = r_st2 == S_IDLE ? data2 : r_wd2;
    w_fin1 = !reset && w_nx1 == S_DONE;
    w_fin2 = !reset && w_nx2 == S_DONE;
    w_col  = FWD && w_fin1 && w_fin2 && w_wr2 && w_a1 == w_a2;
    ready1 = r_st1 == S_DONE;
    ready2 = r_st2 == S_DONE;
  end
  assign data1 = r_data1;
  assign data2 = (r_st2 == S_DONE && !r_wr2) ? r_data2 : {WORD_SIZE{1'bz}};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt1  <= 4'd0;
      r_cnt2  <= 4'd0;
      r_data1 <= '0;
      r_data2 <= '0;
    end else begin
      if (r_st1 == S_IDLE && readM1) begin
        r_addr1 <= w_a1;
        r_cnt1  <= CNT_INIT;
      end else if (r_st1 == S_WAIT) r_cnt1 <= r_cnt1 - 4'd1;
      if (r_st2 == S_IDLE && w_req2) begin
        r_addr2 <= w_a2;
        r_wr2   <= writeM2;
        r_wd2   <= data2;
        r_cnt2  <= CNT_INIT;
      end else if (r_st2 == S_WAIT) r_cnt2 <= r_cnt2 - 4'd1;
      if (w_fin1) r_data1 <= w_col ? w_wd2 : r_mem[w_a1];
      if (w_fin2 && !w_wr2) r_data2 <= r_mem[w_a2];
    end
  end
  always_ff @(posedge clk) begin
    if (w_fin2 && w_wr2) r_mem[w_a2] <= w_wd2;
  end
endmodule
